bomb_scheduler: RTL and testbench
=================================

BOMB_SCHEDULER -- requirements
Module: bomb_scheduler

Interface
REQ-001 SHALL have parameter NSLOT, default 4, number of shared bomb slots.
REQ-002 SHALL have parameter FUSE_TICKS, default 3, ticks from placement to explosion.
REQ-003 SHALL have parameter BLAST_TICKS, default 1, ticks an explosion stays active.
REQ-004 SHALL have parameter RANGE, default 1, blast arm length in cells.
REQ-005 SHALL have parameter HEALTH_INIT, default 3, starting health per player.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port tick, input, 1, one-cycle pulse per bomb period.
REQ-009 SHALL have ports a_req and b_req, input, 1 each, debounced drop buttons (level).
REQ-010 SHALL have ports a_x, a_y, b_x, b_y, input, 4 each, current player grid cells.
REQ-011 SHALL have ports a_grant, b_grant, a_deny, b_deny, output, 1 each, one-cycle request outcomes.
REQ-012 SHALL have ports a_health and b_health, output, 2 each, remaining health.
REQ-013 SHALL have ports slot_fuse and slot_blast, output, NSLOT each, per-slot state flags.
REQ-014 SHALL have ports slot_x and slot_y, output, 4*NSLOT each, packed slot cells, slot i at bits [4i+3:4i].
REQ-015 SHALL have ports game_over, output, 1, and winner, output, 2 (01 A, 10 B, 11 draw, 00 none).

Function
REQ-016 SHALL detect rising edges of a_req/b_req and set a per-player pending flag; held levels SHALL NOT re-trigger.
REQ-017 SHALL resolve at most one pending request per cycle; the grant or deny pulse SHALL occur the cycle after the pending flag is set, at the earliest.
REQ-018 SHALL arbitrate simultaneous pending requests round-robin; pointer favours A after reset and toggles after each served request; the unserved request stays pending.
REQ-019 SHALL grant only if a slot is IDLE, no non-IDLE slot holds the requester's cell, and game_over is 0; otherwise it SHALL pulse deny and clear pending.
REQ-020 SHALL allocate the lowest-index IDLE slot, latching requester x/y into it.
REQ-021 Each slot SHALL be a state machine IDLE -> FUSE -> BLAST -> IDLE; grant enters FUSE with counter=FUSE_TICKS.
REQ-022 In FUSE or BLAST, each tick SHALL decrement the counter; at 1 -> transition (FUSE->BLAST with counter=BLAST_TICKS, BLAST->IDLE).
REQ-023 A tick coincident with a slot's grant cycle SHALL NOT decrement that slot.
REQ-024 slot_fuse[i]/slot_blast[i] SHALL be registered and equal state FUSE/BLAST; slot_x/slot_y SHALL hold the last latched cell.
REQ-025 A player SHALL be hit by a slot entering BLAST when (px==bx and |py-by|<=RANGE) or (py==by and |px-bx|<=RANGE), positions sampled that cycle.
REQ-026 A hit player's health SHALL decrement by exactly 1 per cycle regardless of how many slots hit it; it SHALL saturate at 0.
REQ-027 A player standing in an already active BLAST SHALL NOT take further damage from that slot.
REQ-028 game_over SHALL assert the cycle after any health reaches 0 and stay set until rst; winner latches the same cycle (11 if both 0).
REQ-029 After game_over, slots SHALL continue timing and health updates, but winner SHALL NOT change.

Reset
REQ-030 On rst, all slots IDLE, counters 0, slot_x/slot_y 0, pending flags and edge detectors cleared (held req not a new edge), grants/denies 0.
REQ-031 On rst, a_health=b_health=HEALTH_INIT, game_over=0, winner=00, arbitration pointer=A.
REQ-032 rst mid-operation SHALL abort all fuses and blasts with no damage applied that cycle.

Verification
REQ-033 A at (1,1) rises a_req -> a_grant one cycle later, slot0 FUSE at (1,1); after 3 ticks slot_blast[0]=1, a_health 3->2.
REQ-034 a_req and b_req rise same cycle at (1,1) and (5,5) -> a_grant first, b_grant next cycle in slot1; pointer favours A again after.
REQ-035 Fill 4 slots, fifth request -> deny pulse, no slot change; request at occupied cell with free slot -> deny.
REQ-036 Two bombs explode same tick both covering B -> b_health decrements by 1 only; B at distance 2 -> no hit.
REQ-037 Drive b_health to 0 via 3 blasts -> game_over=1, winner=01; later a_req -> a_deny.
REQ-038 Assert rst during FUSE with tick -> all slots IDLE, health 3, no grant/deny pulses, held buttons do not re-trigger.

Source files
------------

// File: rtl/bomb_scheduler.sv
// Two-player bomb scheduler: debounced drop requests are arbitrated into a pool of
// shared bomb slots, each timing fuse and blast phases on a tick, with blast damage and game outcome.
module bomb_scheduler #(
  parameter int NSLOT       = 4,
  parameter int FUSE_TICKS  = 3,
  parameter int BLAST_TICKS = 1,
  parameter int RANGE       = 1,
  parameter int HEALTH_INIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 a_req,
  input  logic                 b_req,
  input  logic [3:0]           a_x,
  input  logic [3:0]           a_y,
  input  logic [3:0]           b_x,
  input  logic [3:0]           b_y,
  output logic                 a_grant,
  output logic                 b_grant,
  output logic                 a_deny,
  output logic                 b_deny,
  output logic [1:0]           a_health,
  output logic [1:0]           b_health,
  output logic [NSLOT-1:0]     slot_fuse,
  output logic [NSLOT-1:0]     slot_blast,
  output logic [4*NSLOT-1:0]   slot_x,
  output logic [4*NSLOT-1:0]   slot_y,
  output logic                 game_over,
  output logic [1:0]           winner
);

  localparam int CMAX = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int RC   = (RANGE > 15) ? 15 : RANGE;
  localparam logic [3:0] RNG = 4'(RC);

  typedef enum logic [1:0] {IDLE, FUSE, BLAST} slot_st_e;

  slot_st_e      st      [NSLOT];
  slot_st_e      st_nxt  [NSLOT];
  logic [CW-1:0] cnt     [NSLOT];
  logic [CW-1:0] cnt_nxt [NSLOT];
  logic [NSLOT-1:0] alloc;

  logic a_prev, b_prev, a_pend, b_pend, ptr;
  logic a_rise, b_rise, serve_a, serve_b;
  logic [3:0] req_x, req_y;
  logic any_idle, occupied, grant_ok;
  logic [IW-1:0] free_idx;
  logic a_hit, b_hit;

  function automatic logic [1:0] sat_dec(input logic [1:0] h);
    return (h == 2'd0) ? 2'd0 : h - 2'd1;
  endfunction

  function automatic logic [3:0] absdiff(input logic [3:0] p, input logic [3:0] q);
    return (p >= q) ? p - q : q - p;
  endfunction

  function automatic logic in_blast(input logic [3:0] px, input logic [3:0] py,
                                    input logic [3:0] bx, input logic [3:0] by);
    return ((px == bx) && (absdiff(py, by) <= RNG)) ||
           ((py == by) && (absdiff(px, bx) <= RNG));
  endfunction

  // Request arbitration: pointer low favours A when both are pending.
  always_comb begin
    a_rise   = a_req & ~a_prev;
    b_rise   = b_req & ~b_prev;
    serve_a  = a_pend & (~b_pend | ~ptr);
    serve_b  = b_pend & ~serve_a;
    req_x    = serve_a ? a_x : b_x;
    req_y    = serve_a ? a_y : b_y;
    any_idle = 1'b0;
    occupied = 1'b0;
    free_idx = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (st[i] == IDLE) begin
        any_idle = 1'b1;
        free_idx = IW'(i);
      end else if (slot_x[4*i +: 4] == req_x && slot_y[4*i +: 4] == req_y) begin
        occupied = 1'b1;
      end
    end
    grant_ok = (serve_a | serve_b) & any_idle & ~occupied & ~game_over;
  end

  // Slot timers; damage is taken only on the FUSE->BLAST transition.
  always_comb begin
    a_hit = 1'b0;
    b_hit = 1'b0;
    alloc = '0;
    for (int i = 0; i < NSLOT; i++) begin
      st_nxt[i]  = st[i];
      cnt_nxt[i] = cnt[i];
      case (st[i])
        IDLE: begin
          if (grant_ok && free_idx == IW'(i)) begin
            alloc[i]   = 1'b1;
            st_nxt[i]  = FUSE;
            cnt_nxt[i] = CW'(FUSE_TICKS);
          end
        end
        FUSE: begin
          if (tick) begin
            if (cnt[i] == CW'(1)) begin
              st_nxt[i]  = BLAST;
              cnt_nxt[i] = CW'(BLAST_TICKS);
              if (in_blast(a_x, a_y, slot_x[4*i +: 4], slot_y[4*i +: 4])) a_hit = 1'b1;
              if (in_blast(b_x, b_y, slot_x[4*i +: 4], slot_y[4*i +: 4])) b_hit = 1'b1;
            end else begin
              cnt_nxt[i] = cnt[i] - CW'(1);
            end
          end
        end
        BLAST: begin
          if (tick) begin
            if (cnt[i] == CW'(1)) begin
              st_nxt[i]  = IDLE;
              cnt_nxt[i] = '0;
            end else begin
              cnt_nxt[i] = cnt[i] - CW'(1);
            end
          end
        end
        default: begin
          st_nxt[i]  = IDLE;
          cnt_nxt[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Capture the current button level so a held button is not seen as a new press.
      a_prev     <= a_req;
      b_prev     <= b_req;
      a_pend     <= 1'b0;
      b_pend     <= 1'b0;
      ptr        <= 1'b0;
      a_grant    <= 1'b0;
      b_grant    <= 1'b0;
      a_deny     <= 1'b0;
      b_deny     <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
      end
      slot_fuse  <= '0;
      slot_blast <= '0;
      slot_x     <= '0;
      slot_y     <= '0;
      a_health   <= 2'(HEALTH_INIT);
      b_health   <= 2'(HEALTH_INIT);
      game_over  <= 1'b0;
      winner     <= 2'b00;
    end else begin
      a_prev  <= a_req;
      b_prev  <= b_req;
      a_pend  <= a_rise | (a_pend & ~serve_a);
      b_pend  <= b_rise | (b_pend & ~serve_b);
      if (serve_a | serve_b) ptr <= ~ptr;
      a_grant <= serve_a & grant_ok;
      a_deny  <= serve_a & ~grant_ok;
      b_grant <= serve_b & grant_ok;
      b_deny  <= serve_b & ~grant_ok;
      for (int i = 0; i < NSLOT; i++) begin
        st[i]         <= st_nxt[i];
        cnt[i]        <= cnt_nxt[i];
        slot_fuse[i]  <= (st_nxt[i] == FUSE);
        slot_blast[i] <= (st_nxt[i] == BLAST);
        if (alloc[i]) begin
          slot_x[4*i +: 4] <= req_x;
          slot_y[4*i +: 4] <= req_y;
        end
      end
      if (a_hit) a_health <= sat_dec(a_health);
      if (b_hit) b_health <= sat_dec(b_health);
      if (!game_over && (a_health == 2'd0 || b_health == 2'd0)) begin
        game_over <= 1'b1;
        winner    <= {a_health == 2'd0, b_health == 2'd0};
      end
    end
  end

endmodule

// File: tb/tb_bomb_scheduler.sv
// Scoreboard bench for bomb_scheduler: a behavioural game model predicts request outcomes
// (queued for a pulse monitor) plus per-cycle slot, health and game-outcome state.
module tb_bomb_scheduler;

  localparam int NSLOT = 4, FUSE_TICKS = 3, BLAST_TICKS = 1, RANGE = 1, HEALTH_INIT = 3;

  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, a_req = 1'b0, b_req = 1'b0;
  logic [3:0] a_x = 4'd0, a_y = 4'd0, b_x = 4'd0, b_y = 4'd0;
  logic a_grant, b_grant, a_deny, b_deny, game_over;
  logic [1:0] a_health, b_health, winner;
  logic [NSLOT-1:0] slot_fuse, slot_blast;
  logic [4*NSLOT-1:0] slot_x, slot_y;

  bomb_scheduler #(.NSLOT(NSLOT), .FUSE_TICKS(FUSE_TICKS), .BLAST_TICKS(BLAST_TICKS),
                   .RANGE(RANGE), .HEALTH_INIT(HEALTH_INIT)) dut (
    .clk(clk), .rst(rst), .tick(tick), .a_req(a_req), .b_req(b_req),
    .a_x(a_x), .a_y(a_y), .b_x(b_x), .b_y(b_y),
    .a_grant(a_grant), .b_grant(b_grant), .a_deny(a_deny), .b_deny(b_deny),
    .a_health(a_health), .b_health(b_health), .slot_fuse(slot_fuse), .slot_blast(slot_blast),
    .slot_x(slot_x), .slot_y(slot_y), .game_over(game_over), .winner(winner));

  always #5 clk = ~clk;

  typedef struct { int cyc; int who; int kind; } ev_t;
  ev_t expq[$];
  int checks = 0, errors = 0, cyc = 0;

  // Reference game state: phase 0 idle, 1 fuse, 2 blast; left = ticks until next phase.
  int m_phase[NSLOT], m_left[NSLOT], m_sx[NSLOT], m_sy[NSLOT];
  bit m_prev_a, m_prev_b, m_pend_a, m_pend_b, m_go;
  int m_turn, m_win, m_ha = HEALTH_INIT, m_hb = HEALTH_INIT;
  int who, px, py, k;
  bit ok, hit_a, hit_b;

  function automatic bit covers(int qx, int qy, int bx, int by);
    int dx, dy;
    dx = (qx > bx) ? qx - bx : bx - qx;
    dy = (qy > by) ? qy - by : by - qy;
    return (qx == bx && dy <= RANGE) || (qy == by && dx <= RANGE);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) begin
        m_phase[i] = 0; m_left[i] = 0; m_sx[i] = 0; m_sy[i] = 0;
      end
      m_prev_a = a_req; m_prev_b = b_req; m_pend_a = 0; m_pend_b = 0; m_turn = 0;
      m_ha = HEALTH_INIT; m_hb = HEALTH_INIT; m_go = 0; m_win = 0;
    end else begin
      who = -1; ok = 0; k = -1;
      if (m_pend_a && m_pend_b) who = m_turn;
      else if (m_pend_a) who = 0;
      else if (m_pend_b) who = 1;
      if (who >= 0) begin
        px = (who == 0) ? int'(a_x) : int'(b_x);
        py = (who == 0) ? int'(a_y) : int'(b_y);
        ok = !m_go;
        for (int i = NSLOT - 1; i >= 0; i--)
          if (m_phase[i] == 0) k = i;
          else if (m_sx[i] == px && m_sy[i] == py) ok = 0;
        if (k < 0) ok = 0;
        expq.push_back('{cyc, who, int'(ok)});
        if (who == 0) m_pend_a = 0; else m_pend_b = 0;
        m_turn = 1 - m_turn;
      end
      if (!m_go && (m_ha == 0 || m_hb == 0)) begin
        m_go = 1;
        m_win = (m_ha == 0 ? 2 : 0) + (m_hb == 0 ? 1 : 0);
      end
      hit_a = 0; hit_b = 0;
      if (tick)
        for (int i = 0; i < NSLOT; i++)
          if (m_phase[i] != 0) begin
            m_left[i]--;
            if (m_left[i] == 0) begin
              if (m_phase[i] == 1) begin
                m_phase[i] = 2; m_left[i] = BLAST_TICKS;
                if (covers(a_x, a_y, m_sx[i], m_sy[i])) hit_a = 1;
                if (covers(b_x, b_y, m_sx[i], m_sy[i])) hit_b = 1;
              end else m_phase[i] = 0;
            end
          end
      if (ok) begin
        m_phase[k] = 1; m_left[k] = FUSE_TICKS; m_sx[k] = px; m_sy[k] = py;
      end
      if (hit_a && m_ha > 0) m_ha--;
      if (hit_b && m_hb > 0) m_hb--;
      if (a_req && !m_prev_a) m_pend_a = 1;
      if (b_req && !m_prev_b) m_pend_b = 1;
      m_prev_a = a_req; m_prev_b = b_req;
    end
  end

  // Monitor: pulses are matched against the scoreboard queue, state against the model.
  always @(negedge clk) begin
    ev_t e;
    int npulse;
    logic [NSLOT-1:0] ef, eb;
    logic [4*NSLOT-1:0] ex, ey;
    if (cyc > 0) begin
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        e = expq.pop_front();
        checks++; errors++;
        $display("FAIL pulse_missing cycle=%0d actual=none expected who=%0d kind=%0d", e.cyc, e.who, e.kind);
      end
      npulse = int'(a_grant) + int'(a_deny) + int'(b_grant) + int'(b_deny);
      if (npulse != 0) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL pulse_unexpected cycle=%0d actual=%b%b%b%b expected=none",
                   cyc, a_grant, a_deny, b_grant, b_deny);
        end else begin
          e = expq.pop_front();
          chk("pulse_who_kind", {npulse, int'(b_grant | b_deny), int'(a_grant | b_grant)},
              {32'd1, e.who, e.kind});
          chk("pulse_cycle", cyc, e.cyc);
        end
      end
      for (int i = 0; i < NSLOT; i++) begin
        ef[i] = (m_phase[i] == 1);
        eb[i] = (m_phase[i] == 2);
        ex[4*i +: 4] = 4'(m_sx[i]);
        ey[4*i +: 4] = 4'(m_sy[i]);
      end
      chk("slot_fuse", slot_fuse, ef);
      chk("slot_blast", slot_blast, eb);
      chk("slot_x", slot_x, ex);
      chk("slot_y", slot_y, ey);
      chk("a_health", a_health, m_ha);
      chk("b_health", b_health, m_hb);
      chk("game_over", game_over, m_go);
      chk("winner", winner, m_win);
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(int n);
    repeat (n) begin tick = 1'b1; step(1); tick = 1'b0; step(1); end
  endtask

  task automatic drop_a(int x, int y);
    a_x = 4'(x); a_y = 4'(y); a_req = 1'b1; step(2); a_req = 1'b0; step(1);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(2); rst = 1'b0; step(1);
  endtask

  initial begin
    b_x = 4'd8; b_y = 4'd8;
    step(3); rst = 1'b0; step(1);

    // Single drop at A's own cell, explodes on the third tick.
    drop_a(1, 1);
    ticks(3);
    chk("single_blast_slot0", slot_blast[0], 1'b1);
    chk("single_blast_a_health", a_health, 2'd2);
    ticks(1);

    // Simultaneous presses, arbitration A first then B.
    do_reset();
    a_x = 4'd1; a_y = 4'd1; b_x = 4'd5; b_y = 4'd5;
    a_req = 1'b1; b_req = 1'b1; step(4); a_req = 1'b0; b_req = 1'b0; step(1);
    chk("arb_slot1_x", slot_x[7:4], 4'd5);
    ticks(5);

    // Fill all slots away from players, fifth request denied, then occupied-cell deny.
    do_reset();
    b_x = 4'd0; b_y = 4'd0;
    for (int i = 0; i < NSLOT; i++) drop_a(10 + i, 12);
    drop_a(15, 15);
    a_x = 4'd0; a_y = 4'd15;
    ticks(5);
    drop_a(10, 10);
    drop_a(10, 10);
    a_x = 4'd0; a_y = 4'd15;
    ticks(5);

    // Two bombs cover B on the same tick, plus one at distance two.
    do_reset();
    b_x = 4'd3; b_y = 4'd3;
    drop_a(2, 3); drop_a(4, 3); drop_a(3, 5);
    a_x = 4'd12; a_y = 4'd12;
    ticks(3);
    chk("double_hit_b_health", b_health, 2'd2);
    ticks(2);

    // Blast B down to zero, then further drops are denied.
    for (int n = 0; n < 6 && m_hb > 0; n++) begin
      drop_a(3, 4);
      a_x = 4'd12; a_y = 4'd12;
      ticks(4);
    end
    step(2);
    chk("game_over_set", game_over, 1'b1);
    chk("winner_a", winner, 2'b01);
    drop_a(7, 7);
    ticks(4);

    // Reset during an active fuse with tick and buttons held.
    do_reset();
    drop_a(2, 2);
    ticks(1);
    a_req = 1'b1; b_req = 1'b1; tick = 1'b1; rst = 1'b1; step(1);
    tick = 1'b0; rst = 1'b0; step(6);
    a_req = 1'b0; b_req = 1'b0; step(2);

    // Randomized play with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) a_req = ~a_req;
      if ($urandom_range(0, 3) == 0) b_req = ~b_req;
      if ($urandom_range(0, 5) == 0) begin a_x = 4'($urandom_range(0, 4)); a_y = 4'($urandom_range(0, 4)); end
      if ($urandom_range(0, 5) == 0) begin b_x = 4'($urandom_range(0, 4)); b_y = 4'($urandom_range(0, 4)); end
      rst = ($urandom_range(0, 249) == 0) || (m_go && $urandom_range(0, 39) == 0);
      step(1);
    end
    rst = 1'b0; tick = 1'b0; a_req = 1'b0; b_req = 1'b0;
    step(4);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
